// File: rtl/decode_stage_if.sv
// Handshake and decoded-token bundle between fetch, decode_stage and execute.
interface decode_stage_if #(parameter int XLEN = 64);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            we;
    logic [XLEN-1:0] imm;
    logic [3:0]      alu_op;
    logic [2:0]      funct3;
    logic            use_imm;
    logic            use_pc;
    logic            word_op;
    logic            md_en;
    logic [2:0]      md_op;
    logic            illegal;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, rs1, rs2, rd, we, imm, alu_op,
               funct3, use_imm, use_pc, word_op, md_en, md_op, illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, rs1, rs2, rd, we, imm, alu_op,
               funct3, use_imm, use_pc, word_op, md_en, md_op, illegal
    );
endinterface

// File: rtl/decode_stage.sv
// Registered RV32I/RV64I (+M, +W) decode stage with illegal detection and operand-source flags.
// Latency 1; 2-entry skid buffer, in_ready comes straight from a flop (no path from out_ready).
module decode_stage #(
    parameter int XLEN     = 64,
    parameter bit ENABLE_M = 0,
    parameter bit ENABLE_W = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    decode_stage_if.slave  bus
);
    localparam int SHW  = (XLEN == 64) ? 6 : 5;
    localparam bit W_EN = ENABLE_W && (XLEN == 64);
    localparam logic [6:0] QSRA = (XLEN == 64) ? 7'b0010000 : 7'b0100000;

    localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010,
                           ALU_OR  = 4'b0011, ALU_XOR = 4'b0101, ALU_NOP = 4'b1010,
                           ALU_SLT = 4'b1011, ALU_SLTU = 4'b1100, ALU_SLL = 4'b1101,
                           ALU_SRL = 4'b1110, ALU_SRA = 4'b1111;

    localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111,
                           OPC_JALR = 7'b1100111, OPC_BRANCH = 7'b1100011, OPC_LOAD = 7'b0000011,
                           OPC_STORE = 7'b0100011, OPC_OPIMM = 7'b0010011, OPC_OP = 7'b0110011,
                           OPC_OPIMM32 = 7'b0011011, OPC_OP32 = 7'b0111011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            we;
        logic [XLEN-1:0] imm;
        logic [3:0]      alu_op;
        logic [2:0]      funct3;
        logic            use_imm;
        logic            use_pc;
        logic            word_op;
        logic            md_en;
        logic [2:0]      md_op;
        logic            illegal;
    } tok_t;

    logic [31:0]     ins;
    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [6:0]      qual;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh, imm_shw;
    logic            ill;
    logic            accept;
    tok_t            dec;
    tok_t            out_q, out_d, skid_q, skid_d;
    logic            out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;

    assign ins     = bus.in_instr;
    assign opc     = ins[6:0];
    assign f3      = ins[14:12];
    assign f7      = ins[31:25];
    assign qual    = (XLEN == 64) ? {1'b0, ins[31:26]} : ins[31:25];
    assign imm_i   = XLEN'($signed(ins[31:20]));
    assign imm_s   = XLEN'($signed({ins[31:25], ins[11:7]}));
    assign imm_b   = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    assign imm_u   = XLEN'($signed({ins[31:12], 12'h000}));
    assign imm_j   = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
    assign imm_sh  = XLEN'(ins[20 +: SHW]);
    assign imm_shw = XLEN'(ins[24:20]);

    always_comb begin
        dec        = '0;
        dec.pc     = bus.in_pc;
        dec.alu_op = ALU_NOP;
        dec.funct3 = f3;
        ill        = 1'b0;
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL: begin
                dec.rd      = ins[11:7];
                dec.we      = 1'b1;
                dec.alu_op  = ALU_ADD;
                dec.use_imm = 1'b1;
                dec.use_pc  = (opc != OPC_LUI);
                dec.imm     = (opc == OPC_JAL) ? imm_j : imm_u;
            end
            OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_OPIMM32: begin
                dec.rs1     = ins[19:15];
                dec.rd      = ins[11:7];
                dec.we      = 1'b1;
                dec.use_imm = 1'b1;
                dec.imm     = imm_i;
                dec.alu_op  = ALU_ADD;
                if (opc == OPC_JALR) begin
                    ill = (f3 != 3'b000);
                end else if (opc == OPC_LOAD) begin
                    ill = (f3 == 3'b111) || (XLEN == 32 && (f3 == 3'b011 || f3 == 3'b110));
                end else if (opc == OPC_OPIMM) begin
                    case (f3)
                        3'b000: dec.alu_op = ALU_ADD;
                        3'b010: dec.alu_op = ALU_SLT;
                        3'b011: dec.alu_op = ALU_SLTU;
                        3'b100: dec.alu_op = ALU_XOR;
                        3'b110: dec.alu_op = ALU_OR;
                        3'b111: dec.alu_op = ALU_AND;
                        default: begin
                            // shifts: funct3 001/101, shamt width follows XLEN
                            dec.imm    = imm_sh;
                            dec.alu_op = (f3 == 3'b001) ? ALU_SLL :
                                         (qual == QSRA) ? ALU_SRA : ALU_SRL;
                            ill = !((qual == 7'd0) || (f3 == 3'b101 && qual == QSRA));
                        end
                    endcase
                end else begin
                    dec.word_op = 1'b1;
                    if (f3 == 3'b001 || f3 == 3'b101) begin
                        dec.imm    = imm_shw;
                        dec.alu_op = (f3 == 3'b001) ? ALU_SLL :
                                     (f7 == 7'b0100000) ? ALU_SRA : ALU_SRL;
                        ill = !((f7 == 7'd0) || (f3 == 3'b101 && f7 == 7'b0100000));
                    end else begin
                        ill = (f3 != 3'b000);
                    end
                    ill = ill || !W_EN;
                end
            end
            OPC_STORE: begin
                dec.rs1     = ins[19:15];
                dec.rs2     = ins[24:20];
                dec.imm     = imm_s;
                dec.alu_op  = ALU_ADD;
                dec.use_imm = 1'b1;
                ill = f3[2] || (XLEN == 32 && f3 == 3'b011);
            end
            OPC_BRANCH: begin
                dec.rs1 = ins[19:15];
                dec.rs2 = ins[24:20];
                dec.imm = imm_b;
                case (f3[2:1])
                    2'b00:   dec.alu_op = ALU_SUB;
                    2'b10:   dec.alu_op = ALU_SLT;
                    2'b11:   dec.alu_op = ALU_SLTU;
                    default: ill = 1'b1;
                endcase
            end
            OPC_OP, OPC_OP32: begin
                dec.rs1     = ins[19:15];
                dec.rs2     = ins[24:20];
                dec.rd      = ins[11:7];
                dec.we      = 1'b1;
                dec.word_op = (opc == OPC_OP32);
                if (f7 == 7'b0000001) begin
                    dec.md_en = 1'b1;
                    dec.md_op = f3;
                    ill = !ENABLE_M || (opc == OPC_OP32 && (f3 == 3'b001 || f3[2:1] == 2'b01));
                end else begin
                    case ({f7, f3})
                        {7'h00, 3'b000}: dec.alu_op = ALU_ADD;
                        {7'h00, 3'b001}: dec.alu_op = ALU_SLL;
                        {7'h00, 3'b010}: dec.alu_op = ALU_SLT;
                        {7'h00, 3'b011}: dec.alu_op = ALU_SLTU;
                        {7'h00, 3'b100}: dec.alu_op = ALU_XOR;
                        {7'h00, 3'b101}: dec.alu_op = ALU_SRL;
                        {7'h00, 3'b110}: dec.alu_op = ALU_OR;
                        {7'h00, 3'b111}: dec.alu_op = ALU_AND;
                        {7'h20, 3'b000}: dec.alu_op = ALU_SUB;
                        {7'h20, 3'b101}: dec.alu_op = ALU_SRA;
                        default:         ill = 1'b1;
                    endcase
                    if (opc == OPC_OP32 && (f3 == 3'b010 || f3 == 3'b011 || f3[2:1] == 2'b11 || f3 == 3'b100))
                        ill = 1'b1;
                end
                if (opc == OPC_OP32 && !W_EN)
                    ill = 1'b1;
            end
            default: ill = 1'b1;
        endcase
        // Illegal tokens still flow to execute, but carry no side effects
        if (ill) begin
            dec         = '0;
            dec.pc      = bus.in_pc;
            dec.funct3  = f3;
            dec.alu_op  = ALU_NOP;
            dec.illegal = 1'b1;
        end
    end

    assign accept = bus.in_valid && !skid_vld_q;

    always_comb begin
        out_d      = out_q;
        out_vld_d  = out_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (flush) begin
            out_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
        end else if (!out_vld_q || bus.out_ready) begin
            if (skid_vld_q) begin
                out_d      = skid_q;
                out_vld_d  = 1'b1;
                skid_vld_d = 1'b0;
            end else begin
                out_vld_d = accept;
                if (accept)
                    out_d = dec;
            end
        end else if (accept) begin
            skid_d     = dec;
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q         <= '0;
            out_q.alu_op  <= ALU_NOP;
            skid_q        <= '0;
            skid_q.alu_op <= ALU_NOP;
            out_vld_q     <= 1'b0;
            skid_vld_q    <= 1'b0;
        end else begin
            out_q      <= out_d;
            skid_q     <= skid_d;
            out_vld_q  <= out_vld_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    assign bus.in_ready  = !skid_vld_q;
    assign bus.out_valid = out_vld_q;
    assign bus.out_pc    = out_q.pc;
    assign bus.rs1       = out_q.rs1;
    assign bus.rs2       = out_q.rs2;
    assign bus.rd        = out_q.rd;
    assign bus.we        = out_q.we;
    assign bus.imm       = out_q.imm;
    assign bus.alu_op    = out_q.alu_op;
    assign bus.funct3    = out_q.funct3;
    assign bus.use_imm   = out_q.use_imm;
    assign bus.use_pc    = out_q.use_pc;
    assign bus.word_op   = out_q.word_op;
    assign bus.md_en     = out_q.md_en;
    assign bus.md_op     = out_q.md_op;
    assign bus.illegal   = out_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Runs an RV64+M+W and an RV32 (no M) decode_stage in lockstep against a behavioural reference.
module tb_decode_stage;
    localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0001, AND_ = 4'b0010, OR_ = 4'b0011,
                           XOR_ = 4'b0101, NOP = 4'b1010, SLT = 4'b1011, SLTU = 4'b1100,
                           SLL = 4'b1101, SRL = 4'b1110, SRA = 4'b1111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fl;
    logic        iv;
    logic        ordy;
    logic [31:0] ins_r;
    logic [63:0] pc_r;

    always #5 clk = ~clk;

    decode_stage_if #(.XLEN(64)) b64();
    decode_stage_if #(.XLEN(32)) b32();

    assign b64.in_valid  = iv;
    assign b64.in_instr  = ins_r;
    assign b64.in_pc     = pc_r;
    assign b64.out_ready = ordy;
    assign b32.in_valid  = iv;
    assign b32.in_instr  = ins_r;
    assign b32.in_pc     = pc_r[31:0];
    assign b32.out_ready = ordy;

    decode_stage #(.XLEN(64), .ENABLE_M(1), .ENABLE_W(1)) u_d64 (
        .clk(clk), .rst_n(rst_n), .flush(fl), .bus(b64.slave));
    decode_stage #(.XLEN(32), .ENABLE_M(0), .ENABLE_W(1)) u_d32 (
        .clk(clk), .rst_n(rst_n), .flush(fl), .bus(b32.slave));

    typedef struct {
        logic [31:0] ins;
        logic [63:0] pc;
    } tok_t;

    typedef struct {
        logic        ill;
        logic [4:0]  rs1, rs2, rd;
        logic        we;
        logic [63:0] imm;
        logic [3:0]  alu;
        logic [2:0]  f3;
        logic        ui, up, wo, md;
        logic [2:0]  mdop;
    } exp_t;

    tok_t        q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [3:0]  tab [8];

    initial tab = '{ADD, SLL, SLT, SLTU, XOR_, SRL, OR_, AND_};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t ref_dec(input logic [31:0] i, input int xlen, input bit m_en);
        exp_t        e;
        byte         fmt;
        bit          bad, is_sh;
        int          f3, f7, up, shb;
        logic [63:0] shimm;
        e     = '{default: '0};
        f3    = int'(i[14:12]);
        f7    = int'(i[31:25]);
        shb   = (xlen == 64) ? 6 : 5;
        bad   = 1'b0;
        is_sh = 1'b0;
        shimm = '0;
        fmt   = "X";
        e.alu = NOP;
        e.f3  = i[14:12];
        case (i[6:0])
            7'h37: begin fmt = "U"; e.alu = ADD; end
            7'h17: begin fmt = "U"; e.alu = ADD; e.up = 1'b1; end
            7'h6F: begin fmt = "J"; e.alu = ADD; e.up = 1'b1; end
            7'h67: begin fmt = "I"; e.alu = ADD; bad = (f3 != 0); end
            7'h63: begin
                fmt = "B";
                case (f3 / 2)
                    0: e.alu = SUB;
                    2: e.alu = SLT;
                    3: e.alu = SLTU;
                    default: bad = 1'b1;
                endcase
            end
            7'h03: begin fmt = "I"; e.alu = ADD; bad = (f3 == 7) || (xlen == 32 && (f3 == 3 || f3 == 6)); end
            7'h23: begin fmt = "S"; e.alu = ADD; bad = (f3 > 3) || (xlen == 32 && f3 == 3); end
            7'h13: begin
                fmt   = "I";
                e.alu = tab[f3];
                if (f3 == 1 || f3 == 5) begin
                    up    = int'(i[31:20]) >> shb;
                    is_sh = 1'b1;
                    shimm = 64'(int'(i[31:20]) & ((1 << shb) - 1));
                    if (up == 0) ;
                    else if (f3 == 5 && up == (1024 >> shb)) e.alu = SRA;
                    else bad = 1'b1;
                end
            end
            7'h33: begin
                fmt = "R";
                if (f7 == 0) e.alu = tab[f3];
                else if (f7 == 32 && f3 == 0) e.alu = SUB;
                else if (f7 == 32 && f3 == 5) e.alu = SRA;
                else if (f7 == 1 && m_en) begin e.md = 1'b1; e.mdop = i[14:12]; end
                else bad = 1'b1;
            end
            7'h1B: begin
                fmt  = "I";
                e.wo = 1'b1;
                bad  = (xlen != 64);
                if (f3 == 0) e.alu = ADD;
                else if (f3 == 1 || f3 == 5) begin
                    is_sh = 1'b1;
                    shimm = 64'(i[24:20]);
                    if (f7 == 0) e.alu = tab[f3];
                    else if (f3 == 5 && f7 == 32) e.alu = SRA;
                    else bad = 1'b1;
                end else bad = 1'b1;
            end
            7'h3B: begin
                fmt  = "R";
                e.wo = 1'b1;
                bad  = (xlen != 64);
                if (f7 == 0 && (f3 == 0 || f3 == 1 || f3 == 5)) e.alu = tab[f3];
                else if (f7 == 32 && f3 == 0) e.alu = SUB;
                else if (f7 == 32 && f3 == 5) e.alu = SRA;
                else if (f7 == 1 && m_en && !(f3 >= 1 && f3 <= 3)) begin e.md = 1'b1; e.mdop = i[14:12]; end
                else bad = 1'b1;
            end
            default: bad = 1'b1;
        endcase
        case (fmt)
            "R": begin e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7]; e.we = 1'b1; end
            "I": begin e.rs1 = i[19:15]; e.rd = i[11:7]; e.we = 1'b1; e.ui = 1'b1;
                       e.imm = 64'(longint'($signed(i[31:20]))); end
            "S": begin e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.ui = 1'b1;
                       e.imm = 64'(longint'($signed({i[31:25], i[11:7]}))); end
            "B": begin e.rs1 = i[19:15]; e.rs2 = i[24:20];
                       e.imm = 64'(longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}))); end
            "U": begin e.rd = i[11:7]; e.we = 1'b1; e.ui = 1'b1;
                       e.imm = 64'(longint'($signed({i[31:12], 12'h000}))); end
            "J": begin e.rd = i[11:7]; e.we = 1'b1; e.ui = 1'b1;
                       e.imm = 64'(longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}))); end
            default: ;
        endcase
        if (is_sh) e.imm = shimm;
        if (bad) begin
            e     = '{default: '0};
            e.ill = 1'b1;
            e.alu = NOP;
            e.f3  = i[14:12];
        end
        return e;
    endfunction

    task automatic cmp_tok(input tok_t t);
        exp_t a, b;
        a = ref_dec(t.ins, 64, 1'b1);
        b = ref_dec(t.ins, 32, 1'b0);
        chk("pc64", b64.out_pc, t.pc);            chk("pc32", b32.out_pc, 64'(t.pc[31:0]));
        chk("illegal64", b64.illegal, a.ill);     chk("illegal32", b32.illegal, b.ill);
        chk("rs1_64", b64.rs1, a.rs1);            chk("rs1_32", b32.rs1, b.rs1);
        chk("rs2_64", b64.rs2, a.rs2);            chk("rs2_32", b32.rs2, b.rs2);
        chk("rd64", b64.rd, a.rd);                chk("rd32", b32.rd, b.rd);
        chk("we64", b64.we, a.we);                chk("we32", b32.we, b.we);
        chk("imm64", b64.imm, a.imm);             chk("imm32", b32.imm, 64'(b.imm[31:0]));
        chk("alu64", b64.alu_op, a.alu);          chk("alu32", b32.alu_op, b.alu);
        chk("funct3_64", b64.funct3, a.f3);       chk("funct3_32", b32.funct3, b.f3);
        chk("use_imm64", b64.use_imm, a.ui);      chk("use_imm32", b32.use_imm, b.ui);
        chk("use_pc64", b64.use_pc, a.up);        chk("use_pc32", b32.use_pc, b.up);
        chk("word_op64", b64.word_op, a.wo);      chk("word_op32", b32.word_op, b.wo);
        chk("md_en64", b64.md_en, a.md);          chk("md_en32", b32.md_en, b.md);
        chk("md_op64", b64.md_op, a.mdop);        chk("md_op32", b32.md_op, b.mdop);
    endtask

    // One clock: drive at posedge+1, check at negedge, advance the 2-deep occupancy model.
    task automatic cycle(input bit v, input logic [31:0] ins, input logic [63:0] pc,
                         input bit ordy_i, input bit fl_i, output bit accepted);
        int   n;
        tok_t t;
        iv    = v;
        ins_r = ins;
        pc_r  = pc;
        ordy  = ordy_i;
        fl    = fl_i;
        @(negedge clk);
        n = q.size();
        chk("in_ready64", b64.in_ready, n < 2);
        chk("in_ready32", b32.in_ready, n < 2);
        chk("out_valid64", b64.out_valid, n > 0);
        chk("out_valid32", b32.out_valid, n > 0);
        if (n > 0 && ordy_i && !fl_i)
            cmp_tok(q[0]);
        accepted = v && (n < 2);
        if (fl_i) begin
            q.delete();
        end else begin
            if (n > 0 && ordy_i)
                void'(q.pop_front());
            if (accepted) begin
                t.ins = ins;
                t.pc  = pc;
                q.push_back(t);
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_ins();
        logic [31:0] r;
        logic [6:0]  opc [11];
        opc = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h1B, 7'h3B};
        r = $urandom;
        if ($urandom_range(0, 11) != 0)
            r[6:0] = opc[$urandom_range(0, 10)];
        case ($urandom_range(0, 3))
            0: r[31:25] = 7'h00;
            1: r[31:25] = 7'h20;
            2: r[31:25] = 7'h01;
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          acc;
        bit          have;
        logic [31:0] cur_ins;
        logic [63:0] cur_pc;
        logic [31:0] dir [6];

        rst_n = 1'b0; fl = 1'b0; iv = 1'b0; ordy = 1'b0; ins_r = '0; pc_r = '0;
        @(negedge clk);
        chk("rst_out_valid64", b64.out_valid, 0); chk("rst_out_valid32", b32.out_valid, 0);
        chk("rst_in_ready64", b64.in_ready, 1);   chk("rst_in_ready32", b32.in_ready, 1);
        chk("rst_alu64", b64.alu_op, NOP);        chk("rst_alu32", b32.alu_op, NOP);
        chk("rst_imm64", b64.imm, 0);             chk("rst_rd64", b64.rd, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed decodes, one per cycle with execute always ready
        cycle(1, 32'h002081B3, 64'h1000, 1, 0, acc);
        chk("add_valid", b64.out_valid, 1); chk("add_rs1", b64.rs1, 1); chk("add_rs2", b64.rs2, 2);
        chk("add_rd", b64.rd, 3); chk("add_alu", b64.alu_op, ADD); chk("add_we", b64.we, 1);
        chk("add_use_imm", b64.use_imm, 0);
        cycle(1, 32'hFFF00093, 64'h1004, 1, 0, acc);
        chk("addi_imm", b64.imm, 64'hFFFF_FFFF_FFFF_FFFF); chk("addi_use_imm", b64.use_imm, 1);
        cycle(1, 32'h42135293, 64'h1008, 1, 0, acc);
        chk("srai_alu", b64.alu_op, SRA); chk("srai_shamt", 64'(b64.imm[5:0]), 33);
        chk("srai_illegal", b64.illegal, 0);
        chk("srai32_illegal", b32.illegal, 1); chk("srai32_we", b32.we, 0);
        cycle(1, 32'h022081B3, 64'h100C, 1, 0, acc);
        chk("mul_md_en", b64.md_en, 1); chk("mul_md_op", b64.md_op, 0); chk("mul_we", b64.we, 1);
        chk("mul_noM_illegal", b32.illegal, 1); chk("mul_noM_we", b32.we, 0);
        cycle(1, 32'h002081BB, 64'h1010, 1, 0, acc);
        chk("addw_word_op", b64.word_op, 1); chk("addw_alu", b64.alu_op, ADD);
        chk("addw32_illegal", b32.illegal, 1);
        dir = '{32'h123450B7, 32'h00001297, 32'hFE5FF0EF, 32'hFE208EE3, 32'h0020B423, 32'hFFFFFFFF};
        foreach (dir[k]) cycle(1, dir[k], 64'h2000 + 64'(k * 4), 1, 0, acc);
        cycle(0, '0, '0, 1, 0, acc);

        // Backpressure: two accepted, third refused until execute drains
        cycle(1, 32'h00100093, 64'h3000, 0, 0, acc);
        cycle(1, 32'h00200113, 64'h3004, 0, 0, acc);
        cycle(1, 32'h00300193, 64'h3008, 0, 0, acc);
        chk("bp_third_refused", acc, 0);
        chk("bp_in_ready", b64.in_ready, 0);
        acc = 0;
        for (int k = 0; k < 8 && !acc; k++) cycle(1, 32'h00300193, 64'h3008, 1, 0, acc);
        chk("bp_third_accepted", acc, 1);
        repeat (3) cycle(0, '0, '0, 1, 0, acc);

        // Flush with both entries full, then flush while accepting an input
        cycle(1, 32'h00400213, 64'h4000, 0, 0, acc);
        cycle(1, 32'h00500293, 64'h4004, 0, 0, acc);
        cycle(0, '0, '0, 0, 1, acc);
        chk("flush_out_valid", b64.out_valid, 0); chk("flush_in_ready", b64.in_ready, 1);
        cycle(1, 32'h00600313, 64'h4008, 0, 0, acc);
        cycle(1, 32'h00700393, 64'h400C, 0, 1, acc);
        chk("flush_drop_valid", b64.out_valid, 0);
        repeat (2) cycle(0, '0, '0, 1, 0, acc);

        // Asynchronous reset with two tokens held
        cycle(1, 32'h00800413, 64'h5000, 0, 0, acc);
        cycle(1, 32'h00900493, 64'h5004, 0, 0, acc);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid64", b64.out_valid, 0); chk("arst_out_valid32", b32.out_valid, 0);
        chk("arst_alu64", b64.alu_op, NOP);        chk("arst_alu32", b32.alu_op, NOP);
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycle(0, '0, '0, 1, 0, acc);

        // Random traffic: fetch holds a token until accepted
        have = 0; cur_ins = '0; cur_pc = '0;
        for (int c = 0; c < 3000; c++) begin
            bit v;
            if (!have) begin
                cur_ins = rnd_ins();
                cur_pc  = {$urandom, $urandom};
                have    = 1;
            end
            v = ($urandom_range(0, 9) < 7);
            cycle(v, cur_ins, cur_pc, $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0, acc);
            if (acc) have = 0;
        end
        repeat (3) cycle(0, '0, '0, 1, 0, acc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered RISC-V instruction decode stage (RV32I/RV64I base, optional M and RV64 W-variants).
- Sits between the fetch stage and the register-file/ALU stage.
- Uses a valid/ready handshake with a 2-entry skid buffer, so fetch and execute can stall independently.
- Adds illegal-instruction detection, operand-source flags, flush, and XLEN parametrisation on top of the existing combinational field/ALU-code decode.

Parameters:
- XLEN, 64, datapath width (32 or 64); sets imm/pc width and shamt width (5 or 6).
- ENABLE_M, 0, 1 = decode MUL/DIV/REM family (and MULW etc. when XLEN=64).
- ENABLE_W, 1, 1 = decode OP-32 (0111011) / OP-IMM-32 (0011011); forced off when XLEN=32.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  fetch token valid.
- in_ready  out  1  stage can accept.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction PC.
- out_valid  out  1  decoded token valid.
- out_ready  in  1  execute accepts.
- out_pc  out  XLEN  PC passthrough.
- rs1, rs2, rd  out  5 each  register addresses (0 when unused).
- we  out  1  register write enable.
- imm  out  XLEN  sign-extended immediate.
- alu_op  out  4  ALU code: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0101, NOP 1010, SLT 1011, SLTU 1100, SLL 1101, SRL 1110, SRA 1111.
- funct3  out  3  raw funct3 (branch/load/store qualifier).
- use_imm  out  1  ALU operand B = imm.
- use_pc  out  1  ALU operand A = pc (AUIPC, JAL).
- word_op  out  1  32-bit W-variant; result sign-extended from bit 31.
- md_en  out  1  M-extension op; md_op is valid.
- md_op  out  3  funct3 of the M op.
- illegal  out  1  undecodable instruction.

Behaviour:
- Clock and reset: single clock domain. rst_n low asynchronously clears both valid bits.
  - During and after reset: out_valid=0, in_ready=1.
  - Payload registers reset to 0, except alu_op, which resets to NOP (1010).
- Accept: a token is accepted when in_valid && in_ready. It appears on the outputs 1 cycle later (latency 1).
- Output register held: it updates only when empty or when out_valid && out_ready.
- Skid buffer: if a token is accepted while out_valid && !out_ready, it goes to the skid register.
  - in_ready = !skid_valid, driven directly from a flop; no combinational path from out_ready.
  - When the output drains, the skid entry moves to the output in the same edge.
  - Order is always preserved.
- Simultaneous output drain and input accept with skid empty: the new token loads the output register directly.
- Flush: synchronous. Clears output and skid valid bits at the edge. An input accepted in the flush cycle is discarded. in_ready=1 the next cycle.
- Reset mid-transfer: in-flight tokens are lost; no partial output.
- Immediates: I/S/B/U/J formats as in base ISA, sign-extended to XLEN.
  - U-type: imm[31:12] then 12 zeros, sign-extended from bit 31.
- Shift-immediates: shamt = instr[25:20] (XLEN=64) or instr[24:20] (XLEN=32).
  - Qualifier is instr[31:26] for XLEN=64; instr[31:25] otherwise.
  - XLEN=32 with instr[25]=1 → illegal.
  - W shifts: instr[25]=1 → illegal.
- ALU mapping:
  - R/I arithmetic: per funct3/funct7.
  - Load, store, JALR, JAL, LUI, AUIPC: ADD.
  - LUI: rs1=0, use_imm=1.
  - Branch: BEQ/BNE→SUB, BLT/BGE→SLT, BLTU/BGEU→SLTU, use_imm=0.
- use_imm: 1 for OP-IMM, OP-IMM-32, load, store, LUI, AUIPC, JAL, JALR.
- use_pc: 1 for AUIPC and JAL only.
- W ops: alu_op as the base op, word_op=1. Legal W set: ADDW/SUBW/SLLW/SRLW/SRAW, ADDIW/SLLIW/SRLIW/SRAIW.
- M ops (funct7=0000001 on OP/OP-32): md_en=1, md_op=funct3, alu_op=NOP.
  - With ENABLE_M=0 they are illegal.
  - With XLEN=64, MULW/DIVW/DIVUW/REMW/REMUW are decoded; OP-32 with funct7=0000001 and funct3 001/010/011 → illegal.
- Illegal instructions:
  - Causes: unknown opcode; undefined funct3/funct7 combination; W op when disabled; M op when disabled.
  - Response: illegal=1, we=0, rd=0, md_en=0, alu_op=NOP.
  - The token is still passed through with out_valid so execute can raise an exception.
- we=0 for store, branch and illegal. rd=x0 still yields we=1; the register file ignores x0 writes.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), out_ready=1 → next cycle out_valid=1, rs1=1, rs2=2, rd=3, alu_op=0000, we=1, use_imm=0.
- ADDI x1,x0,-1 (0xFFF00093) and SRAI x5,x6,33 (0x42135293), XLEN=64:
  - ADDI: imm=all ones, use_imm=1.
  - SRAI: alu_op=1111, imm[5:0]=33, illegal=0.
  - Same SRAI with XLEN=32 → illegal=1, we=0.
- Backpressure: out_ready=0, present 3 back-to-back tokens → two accepted, in_ready=0 on the third. Raise out_ready → tokens emerge in order, 1/cycle, no loss or duplication.
- Flush with both entries full → out_valid=0 next cycle, in_ready=1. An input accepted during the flush cycle never appears.
- MUL x3,x1,x2 (0x022081B3):
  - ENABLE_M=1: md_en=1, md_op=000, we=1.
  - ENABLE_M=0: illegal=1, we=0.
  - ADDW (0x002081BB): XLEN=64 gives word_op=1, alu_op=0000; XLEN=32 gives illegal=1.
- Assert rst_n low mid-stall with 2 tokens held → out_valid=0 and alu_op=1010 immediately (asynchronous). in_ready=1 after release.
